// File: rtl/rom_arb_pkg.sv
// -----------------------------------------------------------------------------
// rom_arb_pkg
// Shared constants and helpers for the ROM fetch arbiter.
//   ROM_LATENCY : read latency of the shared ROM in clock cycles (address in
//                 at one edge, data out after ROM_LATENCY edges).
//   clog2()     : ceiling log2, used to size the round-robin pointer.
// -----------------------------------------------------------------------------
package rom_arb_pkg;

  localparam int ROM_LATENCY = 1;

  // Ceiling log2 for small positive values; clog2(2)=1, clog2(4)=2, clog2(5)=3.
  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) begin
        result = i + 1;
      end
    end
    return result;
  endfunction

endpackage

// File: rtl/rom_arbiter_rr_pick.sv
// -----------------------------------------------------------------------------
// rr_pick
// Purely combinational round-robin picker.
// Ports:
//   req       in  N : request vector
//   last      in  W : index of the previous winner
//   grant     out N : one-hot grant (all zero when no request)
//   grant_idx out W : index of the granted requester (0 when no request)
// The search starts at last+1: the request vector is rotated so that bit
// last+1 lands at position 0, the lowest set bit is found, and the position
// is rotated back to an absolute index.
// -----------------------------------------------------------------------------
module rr_pick
  import rom_arb_pkg::*;
#(
  parameter int N = 2,
  localparam int W = clog2(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] last,
  output logic [N-1:0] grant,
  output logic [W-1:0] grant_idx
);

  logic [2*N-1:0] w_req_dbl;
  logic [W:0]     w_start;
  logic [N-1:0]   w_req_rot;
  logic [W-1:0]   w_pos;
  logic           w_found;
  logic [W:0]     w_sum;
  logic [W:0]     w_idx;

  // Doubling the vector turns the rotate into a plain part-select.
  // w_start ranges 1..N, so the select never leaves the doubled vector.
  assign w_req_dbl = {req, req};
  assign w_start   = (W+1)'(last) + (W+1)'(1);
  assign w_req_rot = w_req_dbl[w_start +: N];

  // Lowest set bit of the rotated vector; scanning downward lets the last
  // hit (the lowest index) win without needing a break.
  always_comb begin
    w_found = 1'b0;
    w_pos   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (w_req_rot[i]) begin
        w_found = 1'b1;
        w_pos   = W'(i);
      end
    end
  end

  // Rotate back: start + pos lies in 1..2N-1, one conditional subtract
  // brings it into 0..N-1.
  assign w_sum = w_start + (W+1)'(w_pos);
  assign w_idx = (w_sum >= (W+1)'(N)) ? (w_sum - (W+1)'(N)) : w_sum;

  assign grant_idx = w_found ? W'(w_idx) : '0;
  assign grant     = w_found ? (N'(1) << grant_idx) : '0;

endmodule

// File: rtl/rom_arbiter.sv
// -----------------------------------------------------------------------------
// rom_arbiter
// Shares one synchronous ROM between NUM_REQ fetch requesters using a
// round-robin grant. One read is accepted per cycle; the ROM word comes back
// ROM_LATENCY cycles later with a one-hot valid strobe naming the requester.
// Ports:
//   clk       in  1                 : clock, rising edge
//   reset     in  1                 : synchronous, active-low
//   req       in  NUM_REQ           : level fetch request per requester
//   req_addr  in  NUM_REQ*DEPTH_I   : packed addresses, slice i for requester i
//   gnt       out NUM_REQ           : combinational one-hot grant
//   rvalid    out NUM_REQ           : registered one-hot data-valid strobe
//   rdata     out WIDTH_I           : ROM word (wire from rom_data)
//   rom_addr  out DEPTH_I           : address to the ROM
//   rom_data  in  WIDTH_I           : ROM registered output
// -----------------------------------------------------------------------------
module rom_arbiter
  import rom_arb_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int DEPTH_I = 8,
  parameter int WIDTH_I = 32
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_REQ-1:0]         req,
  input  logic [NUM_REQ*DEPTH_I-1:0] req_addr,
  output logic [NUM_REQ-1:0]         gnt,
  output logic [NUM_REQ-1:0]         rvalid,
  output logic [WIDTH_I-1:0]         rdata,
  output logic [DEPTH_I-1:0]         rom_addr,
  input  logic [WIDTH_I-1:0]         rom_data
);

  localparam int LAST_W = clog2(NUM_REQ);

  logic [LAST_W-1:0]  r_last;
  logic [NUM_REQ-1:0] r_rvalid [ROM_LATENCY];

  logic [NUM_REQ-1:0] w_pick_grant;
  logic [LAST_W-1:0]  w_pick_idx;
  logic [NUM_REQ-1:0] w_gnt;
  logic [DEPTH_I-1:0] w_rom_addr;

  rr_pick #(
    .N (NUM_REQ)
  ) u_pick (
    .req       (req),
    .last      (r_last),
    .grant     (w_pick_grant),
    .grant_idx (w_pick_idx)
  );

  // Holding reset suppresses every grant, so nothing is read and the
  // pointer cannot move while the block is being reset.
  assign w_gnt = reset ? w_pick_grant : '0;

  // One-hot select of the winner's address; zero when nobody is granted.
  always_comb begin
    w_rom_addr = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_gnt[i]) begin
        w_rom_addr = req_addr[i*DEPTH_I +: DEPTH_I];
      end
    end
  end

  // Pointer resets to the top index so that requester 0 is searched first.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_last <= LAST_W'(NUM_REQ - 1);
    end else if (|w_gnt) begin
      r_last <= w_pick_idx;
    end
  end

  // Valid strobe travels alongside the ROM read pipeline. Reset clears every
  // stage so an in-flight read is dropped.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_rvalid[0] <= '0;
    end else begin
      r_rvalid[0] <= w_gnt;
    end
  end

  genvar gi;
  generate
    for (gi = 1; gi < ROM_LATENCY; gi++) begin : g_rvalid_pipe
      always_ff @(posedge clk) begin
        if (!reset) begin
          r_rvalid[gi] <= '0;
        end else begin
          r_rvalid[gi] <= r_rvalid[gi-1];
        end
      end
    end
  endgenerate

  assign gnt      = w_gnt;
  assign rom_addr = w_rom_addr;
  assign rvalid   = r_rvalid[ROM_LATENCY-1];
  assign rdata    = rom_data;

endmodule

// File: doc/rom_arbiter.md
# rom_arbiter

Round-robin arbiter that shares one synchronous instruction ROM (registered output, 1-cycle read latency) between `NUM_REQ` fetch requesters, e.g. two `simple_cpu` cores on one board. It sits between the cores' fetch ports and the single `rom` instance. It grants at most one read per cycle, returns the ROM word with a per-requester valid strobe, and guarantees each active requester is served within `NUM_REQ` cycles.

## Interface
Parameters:
- `NUM_REQ`, 2: number of requesters (2..8).
- `DEPTH_I`, 8: ROM address width.
- `WIDTH_I`, 32: ROM data width.

Ports:
- `clk`  in  1: single clock, all logic on rising edge.
- `reset`  in  1: synchronous, active-low (0 = in reset), sampled on `clk`.
- `req`  in  `NUM_REQ`: fetch request per requester, level.
- `req_addr`  in  `NUM_REQ*DEPTH_I`: packed addresses; requester i uses bits `[i*DEPTH_I +: DEPTH_I]`.
- `gnt`  out  `NUM_REQ`: combinational one-hot grant, same cycle as the accepted `req`.
- `rvalid`  out  `NUM_REQ`: registered one-hot, high the cycle `rdata` is valid for that requester.
- `rdata`  out  `WIDTH_I`: ROM word broadcast to all requesters; equals `rom_data`.
- `rom_addr`  out  `DEPTH_I`: address to ROM.
- `rom_data`  in  `WIDTH_I`: ROM output, valid one cycle after `rom_addr`.

## Operation
- Request rule: requester holds `req[i]`=1 and `req_addr` slice stable until it sees `gnt[i]`=1. It may drop `req` only after the grant. Each grant accepts exactly one word.
- Arbitration: a `last` pointer (log2 `NUM_REQ` bits) holds the most recent winner. The winner is the first asserted `req` scanning `last+1, last+2, …` modulo `NUM_REQ`. With a single requester active, it wins every cycle.
- On a grant to requester k: `gnt[k]`=1, `rom_addr` = slice k, `last` <= k at the edge.
- With no request: `gnt`=0, `rom_addr` = 0, `last` unchanged.
- Response: the `rvalid` register is loaded with `gnt` each edge. `rdata` is passed straight through from `rom_data`.
- Back-to-back: grants may occur every cycle. A requester may be granted in consecutive cycles only if no other request is pending.
- Fairness bound: a continuously asserted request is granted within `NUM_REQ` cycles of assertion.
- Reset (`reset`=0 at an edge): `last` <= `NUM_REQ-1`, so requester 0 wins first after reset. `rvalid` <= 0.
- While `reset`=0: `gnt` is forced to 0 and `rom_addr` to 0, regardless of `req`.
- Reset mid-operation: an outstanding read is discarded. No `rvalid` appears in the cycle after the reset edge.
- `rvalid` never has more than one bit set.

## Timing
- Cycle T: `req[k]`=1 and k wins → `gnt[k]`=1, `rom_addr` = addr_k. All of this is combinational from `req`, `req_addr` and `last`.
- Edge T→T+1: ROM registers the address; `rvalid[k]` <= 1; `last` <= k.
- Cycle T+1: `rvalid[k]`=1 and `rdata` = ROM[addr_k].
- Latency is 1 cycle from grant to data. Throughput is 1 word/cycle aggregate.
- Reset values: `rvalid`=0, `gnt`=0, `rom_addr`=0, `rdata` follows `rom_data` (don't-care when `rvalid`=0), `last`=`NUM_REQ-1`.
- Combinational paths: `req`/`req_addr` → `gnt`/`rom_addr` is permitted; the requester must not make `req` depend combinationally on `gnt`. `rom_data` → `rdata` is a wire.

## Structure
- Shared package `rom_arb_pkg`:
  - `ROM_LATENCY` = 1;
  - function `clog2`, used for the `last` pointer width.
- Sub-module `rr_pick`:
  - parameter `N`;
  - inputs `req[N]` and `last`;
  - outputs one-hot `grant[N]` and index `grant_idx`;
  - purely combinational rotate / priority-encode / rotate-back.
- `rom_arbiter` contains: the `last` register, the `rvalid` register, the address mux and the reset gating.

## Test plan
- Single requester, `NUM_REQ`=2: `req[0]`=1 with addr 0x05 for one cycle → `gnt`=01 that cycle, `rom_addr`=0x05, next cycle `rvalid`=01 and `rdata`=ROM[0x05].
- Contention: `req`=11 continuously, addrs 0x10/0x20, from reset → grants alternate 01,10,01,10, and `rvalid` plus `rdata` follow one cycle later (ROM[0x10], ROM[0x20], …).
- Fairness, `NUM_REQ`=4: requesters 0 and 2 continuously active, requester 3 raised at cycle 5 → requester 3 granted within 4 cycles, order stays rotational, no `gnt` to idle requesters.
- Idle: `req`=0 for 10 cycles → `gnt`=0, `rom_addr`=0, `rvalid`=0, `last` unchanged; the next request still resumes rotation from the stored `last`.
- Reset mid-read: grant to requester 1 at T, `reset`=0 sampled at edge T→T+1 → `rvalid`=0 at T+1, `gnt`=0 while in reset; after release with `req`=11, requester 0 wins first.
- Random stress: random `req`/addr, with a scoreboard checking that each grant yields exactly one `rvalid` with the matching ROM word, that `gnt` and `rvalid` are one-hot or zero, and that no wait exceeds `NUM_REQ` cycles.
